regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS core. It is the successor to the single-write, dual-read register file.
- Configurable read-port and write-port counts.
- Optional hardwired zero register.
- Optional write-to-read bypass.
- Per-register busy scoreboard for multi-cycle producers.

It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high; clears all registers and busy bits
wen  in  NUM_WR  write enable per write port
waddr  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
wdata  in  NUM_WR*DATA_W  write data, packed the same way
raddr  in  NUM_RD*ADDR_W  read addresses
rdata  out  NUM_RD*DATA_W  read data (combinational)
rbusy  out  NUM_RD  read register has an outstanding producer (combinational)
sb_set  in  1  mark sb_addr busy (issue of a multi-cycle producer)
sb_addr  in  ADDR_W  scoreboard set address
busy_cnt  out  ADDR_W+1  number of busy registers (registered)

Behaviour:
- Reset (async, rst=1): every register is 0, every busy bit is 0, busy_cnt=0. rdata=0 for all ports and rbusy=0 while rst is held.
- Writes, on the rising clk edge:
  - For each k with wen[k]=1, reg[waddr[k]] <= wdata[k].
  - Both ports hitting the same address: the higher port index wins; the other write is dropped.
  - ZERO_REG=1: writes to address 0 are discarded.
- Reads, combinational:
  - rdata[i] = reg[raddr[i]], zero latency.
  - ZERO_REG=1 and raddr[i]=0: rdata[i]=0, rbusy[i]=0 regardless of writes.
- Bypass (BYPASS=1):
  - If wen[k]=1 and waddr[k]=raddr[i] (and the address is not a discarded zero-register write), rdata[i]=wdata[k] in the same cycle.
  - Multiple port hits: the highest k wins, consistent with write priority.
  - BYPASS=0: reads return the pre-edge stored value.
- Scoreboard, registered busy[0..2**ADDR_W-1]:
  - Any wen[k] write to address a clears busy[a] at the edge.
  - sb_set=1 sets busy[sb_addr] at the edge.
  - Set and clear of the same address in the same cycle: set wins, because a new producer is issued after the old one retires.
  - sb_set on an address that is already busy: remains busy, count unchanged.
  - ZERO_REG=1 and sb_addr=0: ignored.
- rbusy[i]:
  - Equals busy[raddr[i]].
  - BYPASS=1: also forced to 0 when a same-cycle write hits raddr[i], since the data is being forwarded.
- busy_cnt: registered population count of busy bits, updated on the same edge as the busy bits. Range 0..2**ADDR_W, so it never wraps.
- Reset mid-operation: in-flight writes and sets in that cycle are lost; the state returns to the reset values immediately.
- Invariants for verification:
  - No X on rdata for in-range addresses after reset.
  - busy_cnt always equals the popcount of the busy bits.

Decomposition:
- Package regfile_pkg holds:
  - default constants: DATA_W, ADDR_W, NUM_RD, NUM_WR;
  - a function port-slice helper for packed bus indexing;
  - a function popcount over the busy vector.
- Sub-module regfile_rd_port: one per read port via generate. It performs the storage lookup, zero-register masking, priority bypass mux and rbusy derivation.
- The top level owns the storage array, write logic, busy vector and busy_cnt.

Test Plan:
- Reset, then write reg 5 = 0xDEADBEEF via port 0. Read reg 5 the next cycle -> rdata=0xDEADBEEF. Before the edge, with BYPASS=0 -> rdata=0.
- Port 0 writes reg 7 = 0x11 and port 1 writes reg 7 = 0x22 in the same cycle -> rdata for reg 7 = 0x22 both bypassed and after the edge.
- Write reg 0 = 0xFFFFFFFF with ZERO_REG=1 -> reading reg 0 returns 0 in the same cycle and later. sb_set to 0 -> busy_cnt stays 0.
- sb_set reg 9 -> next cycle rbusy=1, busy_cnt=1. Write reg 9 = 0x55 -> in that cycle rbusy=0 and rdata=0x55 (bypass). Next cycle busy_cnt=0.
- sb_set reg 3 and write reg 3 in the same cycle -> busy[3] stays 1 and busy_cnt increments to 1.
- Set busy on regs 1..4 (busy_cnt=4), write reg 6, then assert rst mid-cycle -> all outputs are 0 immediately and reg 6 reads 0 after release.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
// Packed-bus slicing and busy-vector population count live here.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;

    // Widest busy vector popcount supports (ADDR_W up to 8).
    localparam int POP_MAX = 256;

    function automatic int port_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int popcount(input logic [POP_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// master drives writes, reads and scoreboard sets; slave is the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
);
    logic [NUM_WR-1:0]        wen;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output wen, waddr, wdata, raddr, sb_set, sb_addr,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  wen, waddr, wdata, raddr, sb_set, sb_addr,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: storage lookup, zero-register masking,
// priority write bypass and busy flag for the addressed register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                 rst_i,
    input  logic [ADDR_W-1:0]                    raddr_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     mem_i,
    input  logic [2**ADDR_W-1:0]                 busy_i,
    input  logic [NUM_WR-1:0]                    wen_i,
    input  logic [NUM_WR*ADDR_W-1:0]             waddr_i,
    input  logic [NUM_WR*DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]                    rdata_o,
    output logic                                 rbusy_o
);
    logic is_zero;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (raddr_i == '0);
        rdata_o = mem_i[raddr_i];
        rbusy_o = busy_i[raddr_i];
        if (BYPASS != 0) begin
            // Ascending scan so the highest write port wins, matching write priority.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wen_i[k] && (waddr_i[port_lo(k, ADDR_W) +: ADDR_W] == raddr_i)) begin
                    rdata_o = wdata_i[port_lo(k, DATA_W) +: DATA_W];
                    rbusy_o = 1'b0;
                end
            end
        end
        if (is_zero || rst_i) begin
            rdata_o = '0;
            rbusy_o = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional zero register, write bypass
// and a per-register busy scoreboard for multi-cycle producers.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;
    logic [POP_MAX-1:0]           busy_ext;
    logic [ADDR_W-1:0]            wa;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wa     = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wa = bus.waddr[port_lo(k, ADDR_W) +: ADDR_W];
            if (bus.wen[k] && !((ZERO_REG != 0) && (wa == '0))) begin
                regs_d[wa] = bus.wdata[port_lo(k, DATA_W) +: DATA_W];
                busy_d[wa] = 1'b0;
            end
        end
        // Set after clear: a new producer issues as the old one retires.
        if (bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0))) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
        busy_ext              = '0;
        busy_ext[DEPTH-1:0]   = busy_d;
        busy_cnt_d            = (ADDR_W+1)'(popcount(busy_ext));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .rst_i   (rst),
            .raddr_i (bus.raddr[port_lo(i, ADDR_W) +: ADDR_W]),
            .mem_i   (regs_q),
            .busy_i  (busy_q),
            .wen_i   (bus.wen),
            .waddr_i (bus.waddr),
            .wdata_i (bus.wdata),
            .rdata_o (bus.rdata[port_lo(i, DATA_W) +: DATA_W]),
            .rbusy_o (bus.rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing
// instance driven with identical stimulus.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        sb_set;
    logic [4:0]  sb_addr;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_b ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_n ();

    assign if_b.wen = wen;       assign if_n.wen = wen;
    assign if_b.waddr = waddr;   assign if_n.waddr = waddr;
    assign if_b.wdata = wdata;   assign if_n.wdata = wdata;
    assign if_b.raddr = raddr;   assign if_n.raddr = raddr;
    assign if_b.sb_set = sb_set; assign if_n.sb_set = sb_set;
    assign if_b.sb_addr = sb_addr; assign if_n.sb_addr = sb_addr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
        dut_n (.clk(clk), .rst(rst), .bus(if_n.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen    = 2'b00;
        sb_set = 1'b0;
    endtask

    // Cross the next rising edge, clear one-shot inputs, settle.
    task automatic edge_step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        idle();
        waddr   = '0;
        wdata   = '0;
        raddr   = {5'd0, 5'd5};
        sb_addr = '0;
        #12;
        chk("rst_rdata", {32'h0, if_b.rdata}, 64'h0);
        chk("rst_rbusy", {62'h0, if_b.rbusy}, 64'h0);
        chk("rst_cnt",   {58'h0, if_b.busy_cnt}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single write, bypassed vs. pre-edge value
        @(negedge clk);
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        #1;
        chk("wr5_byp",    {32'h0, if_b.rdata[31:0]}, 64'hDEADBEEF);
        chk("wr5_nobyp",  {32'h0, if_n.rdata[31:0]}, 64'h0);
        edge_step();
        chk("rd5_after",  {32'h0, if_n.rdata[31:0]}, 64'hDEADBEEF);

        // Both ports write reg 7: port 1 wins
        @(negedge clk);
        wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd5};
        #1;
        chk("wr7_byp_prio", {32'h0, if_b.rdata[63:32]}, 64'h22);
        edge_step();
        chk("rd7_b", {32'h0, if_b.rdata[63:32]}, 64'h22);
        chk("rd7_n", {32'h0, if_n.rdata[63:32]}, 64'h22);

        // Zero register: writes and scoreboard sets ignored
        @(negedge clk);
        wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF}; raddr = {5'd7, 5'd0};
        sb_set = 1'b1; sb_addr = 5'd0;
        #1;
        chk("r0_same",  {32'h0, if_b.rdata[31:0]}, 64'h0);
        chk("r0_busy",  {63'h0, if_b.rbusy[0]}, 64'h0);
        edge_step();
        chk("r0_after", {32'h0, if_b.rdata[31:0]}, 64'h0);
        chk("r0_cnt",   {58'h0, if_b.busy_cnt}, 64'h0);

        // Scoreboard set, then retire via write with bypass
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd9; raddr = {5'd7, 5'd9};
        edge_step();
        chk("sb9_rbusy", {63'h0, if_b.rbusy[0]}, 64'h1);
        chk("sb9_cnt",   {58'h0, if_b.busy_cnt}, 64'h1);
        @(negedge clk);
        wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h55};
        #1;
        chk("wr9_rbusy_b", {63'h0, if_b.rbusy[0]}, 64'h0);
        chk("wr9_rdata_b", {32'h0, if_b.rdata[31:0]}, 64'h55);
        chk("wr9_rbusy_n", {63'h0, if_n.rbusy[0]}, 64'h1);
        edge_step();
        chk("wr9_cnt",   {58'h0, if_b.busy_cnt}, 64'h0);
        chk("wr9_rdata", {32'h0, if_n.rdata[31:0]}, 64'h55);

        // Set and clear same register: set wins
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd3; wen = 2'b10; waddr = {5'd3, 5'd0};
        wdata = {32'hAA, 32'h0}; raddr = {5'd7, 5'd3};
        edge_step();
        chk("sb3_rbusy", {63'h0, if_n.rbusy[0]}, 64'h1);
        chk("sb3_cnt",   {58'h0, if_b.busy_cnt}, 64'h1);
        chk("sb3_rdata", {32'h0, if_n.rdata[31:0]}, 64'hAA);

        // Re-set an already busy register: count unchanged
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd3;
        edge_step();
        chk("sb3_again_cnt", {58'h0, if_b.busy_cnt}, 64'h1);

        for (int a = 1; a <= 4; a++) begin
            @(negedge clk);
            sb_set = 1'b1; sb_addr = 5'(a);
            edge_step();
        end
        chk("sb1to4_cnt", {58'h0, if_b.busy_cnt}, 64'h4);

        // Reset in the middle of a write cycle
        @(negedge clk);
        wen = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h66}; raddr = {5'd1, 5'd6};
        #1;
        chk("wr6_byp",    {32'h0, if_b.rdata[31:0]}, 64'h66);
        chk("pre_rst_b1", {63'h0, if_b.rbusy[1]}, 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rdata", {32'h0, if_b.rdata[31:0]}, 64'h0);
        chk("mid_rst_rbusy", {62'h0, if_b.rbusy}, 64'h0);
        chk("mid_rst_cnt",   {58'h0, if_b.busy_cnt}, 64'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        raddr = {5'd7, 5'd6};
        #1;
        chk("post_rst_r6", {32'h0, if_n.rdata[31:0]}, 64'h0);
        chk("post_rst_r7", {32'h0, if_n.rdata[63:32]}, 64'h0);
        chk("post_rst_cnt", {58'h0, if_n.busy_cnt}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
